// File: rtl/sr_ff_bank.sv
// Purpose : WIDTH-channel bank of single-bit state elements sharing one common SR/JK/D/T mode.
// Latency : one clock edge from the inputs to q/changed/invalid; qbar follows q combinationally.
// Backpr. : none; a low en freezes all state and zeroes the pulse outputs for that edge.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset (highest priority)
//   en              global update enable
//   mode            00 SR, 01 JK, 10 D, 11 T
//   a / b           S,J,D,T / R,K per channel (b unused in D and T)
//   clr_err         clears err_sticky unless a new invalid event lands on the same edge
//   q / qbar        registered state and its complement
//   changed         one-cycle pulse per channel whose q moved on the last edge
//   invalid         one-cycle pulse per channel that saw S=R=1 in SR mode
//   err_sticky      latched "any invalid seen" flag
//   err_count       saturating count of edges with any invalid bit
//
// Optional feature: define SR_FF_BANK_ERRCNT_EN to build the err_count counter;
// otherwise err_count is tied to zero.
module sr_ff_bank #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      INVALID_POLICY = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE    = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] invalid,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_changed;
  logic [WIDTH-1:0] r_invalid;
  logic             r_err_sticky;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_inv;
  logic             w_any_inv;

  // Per-channel next state; w_inv is only meaningful in SR mode.
  always_comb begin
    w_q_next = r_q;
    w_inv    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (mode)
        MODE_SR: begin
          case ({a[i], b[i]})
            2'b01: w_q_next[i] = 1'b0;
            2'b10: w_q_next[i] = 1'b1;
            2'b11: begin
              w_inv[i] = 1'b1;
              case (INVALID_POLICY)
                1:       w_q_next[i] = 1'b0;
                2:       w_q_next[i] = 1'b1;
                3:       w_q_next[i] = ~r_q[i];
                default: w_q_next[i] = r_q[i];
              endcase
            end
            default: w_q_next[i] = r_q[i];
          endcase
        end
        MODE_JK: begin
          case ({a[i], b[i]})
            2'b01:   w_q_next[i] = 1'b0;
            2'b10:   w_q_next[i] = 1'b1;
            2'b11:   w_q_next[i] = ~r_q[i];
            default: w_q_next[i] = r_q[i];
          endcase
        end
        MODE_D:  w_q_next[i] = a[i];
        MODE_T:  w_q_next[i] = r_q[i] ^ a[i];
        default: w_q_next[i] = r_q[i];
      endcase
    end
  end

  // An invalid event only exists on an enabled edge.
  assign w_any_inv = en & (|w_inv);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q          <= RESET_VALUE;
      r_changed    <= '0;
      r_invalid    <= '0;
      r_err_sticky <= 1'b0;
    end else if (en) begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
      r_invalid <= w_inv;
      // A new event outranks a same-edge clear.
      if (w_any_inv) begin
        r_err_sticky <= 1'b1;
      end else if (clr_err) begin
        r_err_sticky <= 1'b0;
      end
    end else begin
      r_changed <= '0;
      r_invalid <= '0;
    end
  end

`ifdef SR_FF_BANK_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] r_err_count;

  // Saturates at all-ones; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_any_inv && (r_err_count != {CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + CNT_ONE;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

  assign q          = r_q;
  assign qbar       = ~r_q;
  assign changed    = r_changed;
  assign invalid    = r_invalid;
  assign err_sticky = r_err_sticky;

endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised multi-channel flip-flop bank: WIDTH independent single-bit state elements sharing one clock. Each cycle all channels update under a common mode (SR, JK, D or T), with a configurable policy for the SR S=R=1 input. The block also reports per-channel change and invalid-input flags and keeps a sticky error flag. It is the general-purpose storage primitive for control and status bits in the FlipsFlopsAndLatches library.

## Interface
Parameters:
- WIDTH, 8, number of channels (≥1)
- INVALID_POLICY, 0, SR-mode response to S=R=1: 0 hold, 1 reset-dominant (q←0), 2 set-dominant (q←1), 3 toggle
- RESET_VALUE, {WIDTH{1'b0}}, q value after reset
- CNT_W, 8, width of err_count (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-high reset
- en  in  1  global update enable
- mode  in  2  00 SR, 01 JK, 10 D, 11 T
- a  in  WIDTH  S / J / D / T per channel
- b  in  WIDTH  R / K per channel; ignored in D and T modes
- clr_err  in  1  clears err_sticky
- q  out  WIDTH  registered state
- qbar  out  WIDTH  ~q, combinational from q
- changed  out  WIDTH  registered; bit i = 1 if q[i] changed on the last clock edge
- invalid  out  WIDTH  registered; bit i = 1 if channel i saw S=R=1 in SR mode on the last enabled edge
- err_sticky  out  1  registered; set by any invalid bit
- err_count  out  CNT_W  saturating invalid-event count (see Configuration)

## Operation
- The next state per channel is computed from the current mode, a and b, and q.
- SR mode:
  - 00: hold
  - 01 (R): q←0
  - 10 (S): q←1
  - 11: apply INVALID_POLICY and raise invalid[i]
- JK mode: 00 hold, 01 q←0, 10 q←1, 11 toggle. Never invalid.
- D mode: q←a.
- T mode: a=1 toggles, a=0 holds.
- mode is sampled each edge; a mode change takes effect on the same edge with no pipeline.
- en=0: q holds; changed and invalid are 0 on that edge; err_sticky and err_count hold.
- changed = q_next ^ q, registered with q.
- err_sticky: set when any invalid bit is generated.
  - clr_err=1 clears it.
  - If clr_err and a new invalid event occur on the same edge, set wins (err_sticky=1).
- An invalid event counts as one per enabled edge, regardless of how many channels were invalid.

## Timing
- Latency is 1 cycle: inputs at edge n appear on q/changed/invalid after edge n. qbar follows q combinationally.
- Reset (evaluated at the edge, highest priority over en, clr_err and all data) sets:
  - q=RESET_VALUE, qbar=~RESET_VALUE
  - changed=0, invalid=0, err_sticky=0, err_count=0
- On the first edge after reset release, changed reflects only real transitions from RESET_VALUE.
- Reset mid-operation discards that cycle's update entirely. No invalid event is counted.
- Pulse outputs (changed, invalid) last exactly one cycle unless the condition repeats on consecutive enabled edges.

## Configuration
- SR_FF_BANK_ERRCNT_EN defined: err_count increments by 1 on every enabled edge that produces any invalid bit.
  - It saturates at 2^CNT_W−1 and never wraps.
  - It is cleared only by reset; clr_err does not affect it.
- Undefined: err_count is tied to 0 and no counter logic is built. The port remains present, and all other behaviour is identical.

## Test plan
- Reset with RESET_VALUE=8'hA5, then en=0 for 3 cycles → q=8'hA5, qbar=8'h5A, changed=0, err_sticky=0 throughout.
- SR mode, en=1, a=8'h0F, b=8'hF0 from q=8'h00 → q=8'h0F, changed=8'h0F, invalid=0. Next edge a=b=0 → q holds, changed=0.
- SR mode, INVALID_POLICY=3, q=8'h0F, a=b=8'h03 → q=8'h0C, invalid=8'h03, err_sticky=1. With SR_FF_BANK_ERRCNT_EN, err_count=1.
- JK mode a=b=8'hFF from q=8'h0C → q=8'hF3, invalid=0. Switch to T mode a=8'h01 → q=8'hF2. Switch to D mode a=8'h3C → q=8'h3C.
- clr_err=1 on the same edge as an SR invalid event → err_sticky stays 1. Next edge clr_err=1 with no invalid → err_sticky=0.
- CNT_W=2 with the macro defined, 5 consecutive enabled invalid edges → err_count=3 (saturated). Reset asserted during an invalid edge → err_count=0 and q=RESET_VALUE.
